demux_feeder: RTL and testbench



---
 rtl/demux_feeder.sv | 153 +++++++++++++++
 tb/tb_demux_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_feeder.sv
// -----------------------------------------------------------------------------
// demux_feeder
//
// Purpose:
//   Sequencer that feeds a 1-to-8 demultiplexer one bit per cycle. A byte is
//   accepted over a valid/ready handshake and latched. The block then walks
//   channels 0..7 on consecutive cycles and presents the matching data bit on
//   y, with the demux select lines and enable driven to match. An optional
//   idle gap of GAP_CYCLES cycles can follow each 8-cycle frame.
//
// Parameters:
//   GAP_CYCLES  idle cycles (enable=0) after each frame, 0..255
//   LSB_FIRST   1: channel n carries din[n]; 0: channel n carries din[7-n]
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   din[7:0]    in   byte to distribute
//   din_valid   in   din is valid
//   din_ready   out  block accepts din this cycle
//   s1, s2, s3  out  demux select lines (s3 = ~ch[2], s1 = ch[1], s2 = ch[0])
//   enable      out  demux enable, high only while a bit is presented
//   y           out  demux data bit
//   busy        out  high while sending a frame or waiting out the gap
//   frame_done  out  one-cycle pulse on the last bit of a frame
// -----------------------------------------------------------------------------
module demux_feeder #(
  parameter int GAP_CYCLES = 0,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       enable,
  output logic       y,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Back-to-back frames are only possible when no gap follows a frame.
  localparam bit         NO_GAP   = (GAP_CYCLES == 0);
  // Counter preload: the GAP state is held for GAP_CYCLES cycles, leaving
  // in the cycle where the counter reads zero.
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] ch_q,    ch_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;

  logic       last_ch;
  logic       xfer;
  logic [2:0] bit_idx;

  assign last_ch = (ch_q == 3'd7);

  // rst_n is folded in so the block never advertises ready while held in
  // reset, even though the state register already reads IDLE.
  assign din_ready = rst_n &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_SEND) && last_ch && NO_GAP));

  assign xfer = din_valid && din_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= 8'h00;
      ch_q      <= 3'd0;
      gap_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      ch_q      <= ch_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    ch_d      = ch_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shreg_d = din;
          ch_d    = 3'd0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!last_ch) begin
          ch_d = ch_q + 3'd1;
        end else if (xfer) begin
          // Only reachable without a gap: start the next frame seamlessly.
          shreg_d = din;
          ch_d    = 3'd0;
        end else if (!NO_GAP) begin
          gap_cnt_d = GAP_LOAD;
          state_d   = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 8'h00) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'h01;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (combinational from registers only)
  // ---------------------------------------------------------------------------
  assign bit_idx    = LSB_FIRST ? ch_q : (3'd7 - ch_q);

  assign enable     = (state_q == ST_SEND);
  assign y          = enable && shreg_q[bit_idx];
  assign s3         = enable && !ch_q[2];
  assign s1         = enable && ch_q[1];
  assign s2         = enable && ch_q[0];
  assign frame_done = enable && last_ch;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_demux_feeder.sv
// -----------------------------------------------------------------------------
// tb_demux_feeder
//
// Directed bench for demux_feeder. Instance dut_a uses the defaults
// (GAP_CYCLES=0, LSB_FIRST=1); instance dut_b uses GAP_CYCLES=3, LSB_FIRST=0.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_demux_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [7:0] din_a = 8'h00;
  logic       din_valid_a = 1'b0;
  logic       din_ready_a, s1_a, s2_a, s3_a, enable_a, y_a, busy_a, frame_done_a;

  logic [7:0] din_b = 8'h00;
  logic       din_valid_b = 1'b0;
  logic       din_ready_b, s1_b, s2_b, s3_b, enable_b, y_b, busy_b, frame_done_b;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  demux_feeder dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_a),
    .din_valid  (din_valid_a),
    .din_ready  (din_ready_a),
    .s1         (s1_a),
    .s2         (s2_a),
    .s3         (s3_a),
    .enable     (enable_a),
    .y          (y_a),
    .busy       (busy_a),
    .frame_done (frame_done_a)
  );

  demux_feeder #(.GAP_CYCLES(3), .LSB_FIRST(1'b0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_b),
    .din_valid  (din_valid_b),
    .din_ready  (din_ready_b),
    .s1         (s1_b),
    .s2         (s2_b),
    .s3         (s3_b),
    .enable     (enable_b),
    .y          (y_b),
    .busy       (busy_b),
    .frame_done (frame_done_b)
  );

  // Output bundles: {din_ready, busy, enable, frame_done, s3, s1, s2, y}
  function automatic logic [7:0] outs_a();
    return {din_ready_a, busy_a, enable_a, frame_done_a, s3_a, s1_a, s2_a, y_a};
  endfunction

  function automatic logic [7:0] outs_b();
    return {din_ready_b, busy_b, enable_b, frame_done_b, s3_b, s1_b, s2_b, y_b};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-channel select pattern, channels 0..7 at bits 0..7.
  logic [7:0] s3_pat  = 8'b0000_1111;
  logic [7:0] s1_pat  = 8'b1100_1100;
  logic [7:0] s2_pat  = 8'b1010_1010;
  // Hand-written y sequences, channel n at bit n.
  logic [7:0] y_a5    = 8'b1010_0101;  // 1,0,1,0,0,1,0,1
  logic [7:0] y_96    = 8'b1001_0110;  // 0,1,1,0,1,0,0,1
  logic [7:0] y_3c    = 8'b0011_1100;  // 0,0,1,1,1,1,0,0
  logic [7:0] exp_v;

  initial begin
    // ---------------- 1. reset values ----------------
    #2;
    rst_n       = 1'b0;
    din_a       = 8'hFF;
    din_valid_a = 1'b1;
    din_b       = 8'hFF;
    din_valid_b = 1'b1;
    #1;
    check_eq("rst_a_outs", outs_a(), 8'h00);
    check_eq("rst_b_outs", outs_b(), 8'h00);
    tick();
    tick();
    check_eq("rst_a_hold", outs_a(), 8'h00);
    din_valid_a = 1'b0;
    din_valid_b = 1'b0;
    rst_n       = 1'b1;
    tick();
    // IDLE, ready, no transfer happened during reset
    check_eq("post_rst_a", outs_a(), 8'b1000_0000);
    check_eq("post_rst_b", outs_b(), 8'b1000_0000);

    // ---------------- 2. single byte A5 ----------------
    din_a       = 8'hA5;
    din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
    din_a       = 8'h00;
    for (int n = 0; n < 8; n++) begin
      exp_v = {(n == 7), 1'b1, 1'b1, (n == 7), s3_pat[n], s1_pat[n], s2_pat[n], y_a5[n]};
      check_eq($sformatf("a5_ch%0d", n), outs_a(), exp_v);
      tick();
    end
    check_eq("a5_idle", outs_a(), 8'b1000_0000);

    // ---------------- 3. back-to-back FF, 00 ----------------
    din_a       = 8'hFF;
    din_valid_a = 1'b1;
    tick();
    din_a = 8'h00;
    for (int n = 0; n < 16; n++) begin
      exp_v = {((n % 8) == 7), 1'b1, 1'b1, ((n % 8) == 7),
               s3_pat[n % 8], s1_pat[n % 8], s2_pat[n % 8], (n < 8)};
      check_eq($sformatf("b2b_cyc%0d", n), outs_a(), exp_v);
      if (n == 15) din_valid_a = 1'b0;
      tick();
    end
    check_eq("b2b_idle", outs_a(), 8'b1000_0000);

    // ---------------- 4. gap and MSB-first (dut_b) ----------------
    din_b       = 8'h01;
    din_valid_b = 1'b1;
    tick();
    din_b = 8'h80;  // held valid; must not be taken until the IDLE cycle
    for (int n = 0; n < 8; n++) begin
      exp_v = {1'b0, 1'b1, 1'b1, (n == 7), s3_pat[n], s1_pat[n], s2_pat[n], (n == 7)};
      check_eq($sformatf("gap_ch%0d", n), outs_b(), exp_v);
      tick();
    end
    for (int n = 0; n < 3; n++) begin
      check_eq($sformatf("gap_idle%0d", n), outs_b(), 8'b0100_0000);
      tick();
    end
    check_eq("gap_accept", outs_b(), 8'b1000_0000);
    tick();
    // 12 cycles after the first accept: 8'h80 MSB-first puts 1 on channel 0
    check_eq("gap_2nd_ch0", outs_b(), 8'b0110_1001);
    din_valid_b = 1'b0;

    // ---------------- 5. upstream stall ----------------
    din_a       = 8'h96;
    din_valid_a = 1'b1;
    tick();
    for (int n = 0; n < 8; n++) begin
      din_a       = ~din_a ^ 8'(n * 37);
      din_valid_a = (n != 7) && n[0];
      exp_v = {(n == 7), 1'b1, 1'b1, (n == 7), s3_pat[n], s1_pat[n], s2_pat[n], y_96[n]};
      check_eq($sformatf("stall_ch%0d", n), outs_a(), exp_v);
      tick();
    end
    check_eq("stall_idle", outs_a(), 8'b1000_0000);

    // ---------------- 6. reset mid-frame ----------------
    din_a       = 8'hE7;
    din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
    tick();
    tick();
    tick();
    check_eq("mid_ch3", outs_a(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_async", outs_a(), 8'h00);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_rel", outs_a(), 8'b1000_0000);
    din_a       = 8'h3C;
    din_valid_a = 1'b1;
    tick();
    din_valid_a = 1'b0;
    for (int n = 0; n < 8; n++) begin
      exp_v = {(n == 7), 1'b1, 1'b1, (n == 7), s3_pat[n], s1_pat[n], s2_pat[n], y_3c[n]};
      check_eq($sformatf("r3c_ch%0d", n), outs_a(), exp_v);
      tick();
    end
    check_eq("r3c_idle", outs_a(), 8'b1000_0000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
